// File: rtl/svk_apb_mst_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// Define SVK_APB_ARB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYC cycles for pready.
module svk_apb_mst_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]  req_strb,
    input  logic [NUM_REQ*3-1:0]         req_prot,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_slverr,
    output logic [ADDR_W-1:0]            paddr,
    output logic                         psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [DATA_W-1:0]            pwdata,
    output logic [DATA_W/8-1:0]          pstrb,
    output logic [2:0]                   pprot,
    input  logic [DATA_W-1:0]            prdata,
    input  logic                         pready,
    input  logic                         pslverr
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   win;
    logic               win_found;
    logic               grant_win;
    logic               accept;
    logic [NUM_REQ-1:0] owner_hot;
    int unsigned        idx;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
    logic [STRB_W-1:0]  strb_arr  [NUM_REQ];
    logic [2:0]         prot_arr  [NUM_REQ];

    // Unpack the flat per-requester buses
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
        assign strb_arr[g]  = req_strb[g*STRB_W +: STRB_W];
        assign prot_arr[g]  = req_prot[g*3 +: 3];
    end

    // First valid requester at or after the round-robin pointer
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!win_found && req_valid[PTR_W'(idx)]) begin
                win_found = 1'b1;
                win       = PTR_W'(idx);
            end
        end
    end

    assign grant_win = (state == IDLE) || ((state == ACCESS) && pready);
    assign accept    = grant_win && win_found && !preset;
    assign owner_hot = NUM_REQ'(1) << owner;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready = NUM_REQ'(1) << win;
    end

`ifdef SVK_APB_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // APB sequencing; a grant in the same cycle overrides the return to IDLE
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            pstrb      <= '0;
            pprot      <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
`ifdef SVK_APB_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            unique case (state)
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid  <= owner_hot;
                        rsp_rdata  <= prdata;
                        rsp_slverr <= pslverr;
                        state      <= IDLE;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                    end
`ifdef SVK_APB_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        rsp_valid  <= owner_hot;
                        rsp_rdata  <= '0;
                        rsp_slverr <= 1'b1;
                        state      <= IDLE;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                default: ;
            endcase
            if (accept) begin
                state   <= SETUP;
                psel    <= 1'b1;
                penable <= 1'b0;
                owner   <= win;
                ptr     <= (32'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
                pwrite  <= req_write[win];
                paddr   <= addr_arr[win];
                pwdata  <= wdata_arr[win];
                pstrb   <= strb_arr[win];
                pprot   <= prot_arr[win];
`ifdef SVK_APB_ARB_TIMEOUT_EN
                tmo_cnt <= '0;
`endif
            end
        end
    end

endmodule

// File: doc/svk_apb_mst_arbiter.md
# svk_apb_mst_arbiter

Multi-requester APB master controller that shares one APB bus among `NUM_REQ` internal requesters. It accepts transfer requests over a valid/ready handshake and arbitrates them round-robin. It sequences each granted request through the APB SETUP/ACCESS phases and returns read data and error status to the originating requester. It sits between the sequencer-side command sources and the `svk_apb_if` master-side signal bundle, and drives the same signal set that the interface's protocol assertions check.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ADDR_W`, 32: paddr width.
- `DATA_W`, 32: pwdata/prdata width; `STRB_W = DATA_W/8`.
- `TIMEOUT_CYC`, 1024: ACCESS-phase wait limit. Used only with the timeout macro.

Ports:
- `pclk`  in  1  APB clock; all state on rising edge.
- `preset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot grant/accept; combinational.
- `req_write`  in  NUM_REQ  1 = write.
- `req_addr`  in  NUM_REQ*ADDR_W  packed; requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  NUM_REQ*DATA_W  packed as above.
- `req_strb`  in  NUM_REQ*STRB_W  packed as above.
- `req_prot`  in  NUM_REQ*3  packed as above.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  read data; valid with `rsp_valid`.
- `rsp_slverr`  out  1  error status; valid with `rsp_valid`.
- `paddr`  out  ADDR_W.
- `psel`  out  1.
- `penable`  out  1.
- `pwrite`  out  1.
- `pwdata`  out  DATA_W.
- `pstrb`  out  STRB_W.
- `pprot`  out  3.
- `prdata`  in  DATA_W.
- `pready`  in  1.
- `pslverr`  in  1.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- Grant window is IDLE, or ACCESS with `pready=1`. In the grant window, the arbiter picks the winner among `req_valid` and raises `req_ready[winner]` in the same cycle. A winner exists only if some `req_valid` bit is set.
- Handshake: `req_valid[i] & req_ready[i]` at a rising edge.
  - The requester's addr/wdata/strb/prot/write fields are registered into the APB output registers.
  - The FSM moves to SETUP.
- Requesters hold `req_valid` and their fields stable until accepted. `req_valid` must not drop before `req_ready`.
- Round-robin arbitration:
  - The pointer resets to 0, so requester 0 has highest priority first.
  - After a grant to requester i, the pointer becomes (i+1) mod NUM_REQ.
  - The pointer changes only on a handshake.
- SETUP: `psel=1`, `penable=0`. Lasts exactly one cycle, then ACCESS.
- ACCESS: `psel=1`, `penable=1`. Wait states extend ACCESS while `pready=0`, with all APB outputs held stable.
- Completion is the edge with ACCESS & `pready=1`:
  - `rsp_valid[owner]` pulses for the next cycle.
  - `rsp_rdata` is captured from `prdata`, both reads and writes; it is don't-care for writes.
  - `rsp_slverr` is captured from `pslverr`.
- On completion with no pending request: go to IDLE, `psel=0`, `penable=0`. paddr and other address/data outputs hold their last value.
- On completion with a pending request: move directly to SETUP, giving back-to-back transfers with `psel` staying high and `penable` dropping for one cycle.
- Simultaneous `rsp_valid` for the finishing owner and `req_ready` for the next winner are legal. The same requester may receive both.
- `psel=0` never coincides with `penable=1`.

## Timing
- Reset values: every output is 0, including `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_slverr` and all p* outputs. Pointer = 0, state = IDLE.
- Assertion of `preset` mid-transfer:
  - All outputs go to 0 immediately (asynchronous).
  - The in-flight transfer is dropped with no `rsp_valid`.
  - After reset release, pending requests are re-arbitrated from pointer 0.
- Latency from handshake edge N to response:
  - SETUP in cycle N+1, ACCESS from N+2.
  - With zero wait states, `rsp_valid` is high in cycle N+3.
  - Each wait state adds one cycle.
- Back-to-back throughput: 2 cycles per transfer at zero wait states.

## Configuration
- `SVK_APB_ARB_TIMEOUT_EN` defined:
  - A counter runs in ACCESS, cleared on entering SETUP.
  - If `pready` remains 0 for `TIMEOUT_CYC` consecutive ACCESS cycles, the transfer is aborted. `psel` and `penable` go to 0, the FSM goes to IDLE, and `rsp_valid[owner]` pulses with `rsp_slverr=1` and `rsp_rdata=0`.
  - No grant occurs on the abort edge.
- Not defined: no counter. ACCESS waits indefinitely for `pready`.

## Test plan
- Single write: requester 2 writes addr 0x10, data 0xA5A5A5A5, strb 0xF, with `pready` high. Expect SETUP at N+1, ACCESS at N+2, `rsp_valid=4'b0100` at N+3, `rsp_slverr=0`.
- Read with 3 wait states: requester 0 reads 0x20 and the slave returns 0x12345678 with `pslverr=1`. Expect ACCESS held 4 cycles with stable outputs, then `rsp_rdata=0x12345678` and `rsp_slverr=1`.
- Contention: all 4 requesters valid from reset. Expect grant order 0,1,2,3. `psel` stays 1 across all four, `penable` toggles, and each transfer takes 2 cycles.
- Fairness: requesters 1 and 3 both continuously valid. Expect alternating grants 1,3,1,3, never two consecutive grants to the same requester.
- Reset mid-ACCESS: assert `preset` during a wait state. Expect all outputs 0 within the same cycle and no `rsp_valid`. After release, the still-valid requester is re-granted.
- Timeout (macro on, `TIMEOUT_CYC=8`): hold `pready=0`. After 8 ACCESS cycles expect `psel=0` and an `rsp_valid` pulse with `rsp_slverr=1` and `rsp_rdata=0`.
